// File: rtl/vjtag_drv_pkg.sv
// Shared types for the virtual-JTAG host driver: scan state encoding and cmd_len width helper.
package vjtag_drv_pkg;

    typedef enum logic [3:0] {
        IDLE,
        CIR,
        UIR,
        CDR,
        SDR,
        E1DR,
        PDR,
        E2DR,
        UDR
    } vjtag_drv_state_t;

    // Width needed to express a DR length of 0..dr_w inclusive.
    function automatic int cmd_len_width(input int dr_w);
        return $clog2(dr_w + 1);
    endfunction

endpackage

// File: rtl/vjtag_if.sv
// Virtual-JTAG bundle: the host (out) drives tck, tdi, ir_in and the TAP state strobes;
// the user logic (in) answers with tdo and ir_out.
interface vjtag_if #(
    parameter int IR_W = 3
);
    logic            tck;
    logic            tdi;
    logic            tdo;
    logic [IR_W-1:0] ir_in;
    logic [IR_W-1:0] ir_out;
    logic            virtual_state_cdr;
    logic            virtual_state_sdr;
    logic            virtual_state_e1dr;
    logic            virtual_state_pdr;
    logic            virtual_state_e2dr;
    logic            virtual_state_udr;
    logic            virtual_state_cir;
    logic            virtual_state_uir;

    modport out (
        output tck, tdi, ir_in,
        output virtual_state_cdr, virtual_state_sdr, virtual_state_e1dr,
        output virtual_state_pdr, virtual_state_e2dr, virtual_state_udr,
        output virtual_state_cir, virtual_state_uir,
        input  tdo, ir_out
    );

    modport in (
        input  tck, tdi, ir_in,
        input  virtual_state_cdr, virtual_state_sdr, virtual_state_e1dr,
        input  virtual_state_pdr, virtual_state_e2dr, virtual_state_udr,
        input  virtual_state_cir, virtual_state_uir,
        output tdo, ir_out
    );

endinterface

// File: rtl/vjtag_tck_gen.sv
// Free-running tck divider; rise_o/fall_o flag the clk edge on which tck goes 0->1 / 1->0.
module vjtag_tck_gen #(
    parameter int TCK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tck_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;

    logic [CW-1:0] div_cnt_reg;
    logic          tck_reg;
    logic          wrap;

    assign wrap = (div_cnt_reg == CW'(TCK_DIV - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_cnt_reg <= '0;
            tck_reg     <= 1'b0;
        end else if (wrap) begin
            div_cnt_reg <= '0;
            tck_reg     <= ~tck_reg;
        end else begin
            div_cnt_reg <= div_cnt_reg + CW'(1);
        end
    end

    // Pulses are combinational so the FSM updates on the very edge that moves tck.
    assign rise_o = wrap & ~tck_reg;
    assign fall_o = wrap &  tck_reg;
    assign tck_o  = tck_reg;

endmodule

// File: rtl/vjtag_driver.sv
// Host-side virtual-JTAG driver: runs IR/DR scan commands over a vjtag_if bundle.
// Optional PDR/E2DR pause after E1DR is built when VJTAG_DRV_PAUSE_EN is defined.
module vjtag_driver
    import vjtag_drv_pkg::*;
#(
    parameter  int IR_W       = 3,
    parameter  int DR_W       = 32,
    parameter  int TCK_DIV    = 4,
    parameter  int PAUSE_TCKS = 2,
    localparam int LEN_W      = cmd_len_width(DR_W)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic             cmd_is_ir_i,
    input  logic [IR_W-1:0]  cmd_ir_i,
    input  logic [DR_W-1:0]  cmd_data_i,
    input  logic [LEN_W-1:0] cmd_len_i,
    output logic             rsp_valid_o,
    output logic [DR_W-1:0]  rsp_data_o,
    output logic [IR_W-1:0]  rsp_ir_o,
    vjtag_if.out             vjtag
);

    generate
        if (TCK_DIV < 1 || PAUSE_TCKS < 1) begin : g_bad_params
            $error("vjtag_driver: TCK_DIV and PAUSE_TCKS must be >= 1");
        end
    endgenerate

    logic tck;
    logic tck_rise;
    logic tck_fall;

    vjtag_tck_gen #(
        .TCK_DIV(TCK_DIV)
    ) u_tck_gen (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .tck_o (tck),
        .rise_o(tck_rise),
        .fall_o(tck_fall)
    );

    vjtag_drv_state_t state_reg, state_next;
    logic             pending_reg, pending_next;
    logic             is_ir_reg, is_ir_next;
    logic [IR_W-1:0]  ir_cmd_reg, ir_cmd_next;
    logic [DR_W-1:0]  shift_reg, shift_next;
    logic [LEN_W-1:0] remain_reg, remain_next;
    logic [DR_W-1:0]  mask_reg, mask_next;
    logic [DR_W-1:0]  cap_reg, cap_next;
    logic [IR_W-1:0]  ir_cap_reg, ir_cap_next;
    logic             tdi_reg, tdi_next;
    logic [IR_W-1:0]  ir_in_reg, ir_in_next;
    logic             rsp_valid_reg, rsp_valid_next;
    logic [DR_W-1:0]  rsp_data_reg, rsp_data_next;
    logic [IR_W-1:0]  rsp_ir_reg, rsp_ir_next;
    logic [LEN_W-1:0] len_clamped;
    logic             accept;

`ifdef VJTAG_DRV_PAUSE_EN
    localparam int PCW = (PAUSE_TCKS > 1) ? $clog2(PAUSE_TCKS) : 1;
    logic [PCW-1:0] pause_cnt_reg, pause_cnt_next;
`endif

    // A command is only taken between scans, and not while a taken one waits for its first fall.
    assign cmd_ready_o = (state_reg == IDLE) && !pending_reg && !rst_i;
    assign accept      = cmd_valid_i && cmd_ready_o;
    assign len_clamped = (cmd_len_i > LEN_W'(DR_W)) ? LEN_W'(DR_W) : cmd_len_i;

    always_comb begin
        state_next     = state_reg;
        pending_next   = pending_reg;
        is_ir_next     = is_ir_reg;
        ir_cmd_next    = ir_cmd_reg;
        shift_next     = shift_reg;
        remain_next    = remain_reg;
        mask_next      = mask_reg;
        cap_next       = cap_reg;
        ir_cap_next    = ir_cap_reg;
        tdi_next       = tdi_reg;
        ir_in_next     = ir_in_reg;
        rsp_valid_next = 1'b0;
        rsp_data_next  = rsp_data_reg;
        rsp_ir_next    = rsp_ir_reg;
`ifdef VJTAG_DRV_PAUSE_EN
        pause_cnt_next = pause_cnt_reg;
`endif

        if (accept) begin
            pending_next = 1'b1;
            is_ir_next   = cmd_is_ir_i;
            ir_cmd_next  = cmd_ir_i;
            shift_next   = cmd_data_i;
            remain_next  = len_clamped;
            mask_next    = DR_W'(1);
            cap_next     = '0;
        end

        case (state_reg)
            IDLE: begin
                if (pending_reg && tck_fall) begin
                    pending_next = 1'b0;
                    state_next   = is_ir_reg ? CIR : CDR;
                end
            end
            CIR: begin
                if (tck_rise) begin
                    ir_cap_next = vjtag.ir_out;
                end
                if (tck_fall) begin
                    state_next = UIR;
                    ir_in_next = ir_cmd_reg;
                end
            end
            UIR: begin
                if (tck_fall) begin
                    state_next     = IDLE;
                    rsp_valid_next = 1'b1;
                    rsp_ir_next    = ir_cap_reg;
                end
            end
            CDR: begin
                if (tck_fall) begin
                    if (remain_reg == '0) begin
                        state_next = E1DR;
                    end else begin
                        state_next = SDR;
                        tdi_next   = shift_reg[0];
                        shift_next = shift_reg >> 1;
                    end
                end
            end
            SDR: begin
                // mask_reg is one-hot on the bit position of the current shift period.
                if (tck_rise) begin
                    cap_next = cap_reg | (mask_reg & {DR_W{vjtag.tdo}});
                end
                if (tck_fall) begin
                    mask_next   = mask_reg << 1;
                    remain_next = remain_reg - LEN_W'(1);
                    if (remain_reg == LEN_W'(1)) begin
                        state_next = E1DR;
                        tdi_next   = 1'b0;
                    end else begin
                        tdi_next   = shift_reg[0];
                        shift_next = shift_reg >> 1;
                    end
                end
            end
            E1DR: begin
                if (tck_fall) begin
`ifdef VJTAG_DRV_PAUSE_EN
                    state_next     = PDR;
                    pause_cnt_next = '0;
`else
                    state_next     = UDR;
`endif
                end
            end
`ifdef VJTAG_DRV_PAUSE_EN
            PDR: begin
                if (tck_fall) begin
                    if (pause_cnt_reg == PCW'(PAUSE_TCKS - 1)) begin
                        state_next = E2DR;
                    end else begin
                        pause_cnt_next = pause_cnt_reg + PCW'(1);
                    end
                end
            end
            E2DR: begin
                if (tck_fall) begin
                    state_next = UDR;
                end
            end
`endif
            UDR: begin
                if (tck_fall) begin
                    state_next     = IDLE;
                    rsp_valid_next = 1'b1;
                    rsp_data_next  = cap_reg;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg     <= IDLE;
            pending_reg   <= 1'b0;
            is_ir_reg     <= 1'b0;
            ir_cmd_reg    <= '0;
            shift_reg     <= '0;
            remain_reg    <= '0;
            mask_reg      <= '0;
            cap_reg       <= '0;
            ir_cap_reg    <= '0;
            tdi_reg       <= 1'b0;
            ir_in_reg     <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= '0;
            rsp_ir_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            pending_reg   <= pending_next;
            is_ir_reg     <= is_ir_next;
            ir_cmd_reg    <= ir_cmd_next;
            shift_reg     <= shift_next;
            remain_reg    <= remain_next;
            mask_reg      <= mask_next;
            cap_reg       <= cap_next;
            ir_cap_reg    <= ir_cap_next;
            tdi_reg       <= tdi_next;
            ir_in_reg     <= ir_in_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_data_reg  <= rsp_data_next;
            rsp_ir_reg    <= rsp_ir_next;
        end
    end

`ifdef VJTAG_DRV_PAUSE_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pause_cnt_reg <= '0;
        end else begin
            pause_cnt_reg <= pause_cnt_next;
        end
    end
`endif

    // Strobes decode straight from the state register, so they are one-hot and move only at fall.
    assign vjtag.tck                = tck;
    assign vjtag.tdi                = tdi_reg;
    assign vjtag.ir_in              = ir_in_reg;
    assign vjtag.virtual_state_cdr  = (state_reg == CDR);
    assign vjtag.virtual_state_sdr  = (state_reg == SDR);
    assign vjtag.virtual_state_e1dr = (state_reg == E1DR);
    assign vjtag.virtual_state_udr  = (state_reg == UDR);
    assign vjtag.virtual_state_cir  = (state_reg == CIR);
    assign vjtag.virtual_state_uir  = (state_reg == UIR);
`ifdef VJTAG_DRV_PAUSE_EN
    assign vjtag.virtual_state_pdr  = (state_reg == PDR);
    assign vjtag.virtual_state_e2dr = (state_reg == E2DR);
`else
    assign vjtag.virtual_state_pdr  = 1'b0;
    assign vjtag.virtual_state_e2dr = 1'b0;
`endif

    assign rsp_valid_o = rsp_valid_reg;
    assign rsp_data_o  = rsp_data_reg;
    assign rsp_ir_o    = rsp_ir_reg;

endmodule

// File: tb/tb_vjtag_driver.sv
// Directed + randomized bench for vjtag_driver with a loopback user-logic slave
// (tdo = tdi of the previous shift period, cleared at CDR).
module tb_vjtag_driver;

    localparam int IR_W       = 3;
    localparam int DR_W       = 8;
    localparam int TCK_DIV    = 2;
    localparam int PAUSE_TCKS = 2;
    localparam int LEN_W      = $clog2(DR_W + 1);
    localparam int TCK_CLKS   = 2 * TCK_DIV;

    localparam logic [7:0] S_CDR = 8'h01;
    localparam logic [7:0] S_SDR = 8'h02;
    localparam logic [7:0] S_E1  = 8'h04;
    localparam logic [7:0] S_PDR = 8'h08;
    localparam logic [7:0] S_E2  = 8'h10;
    localparam logic [7:0] S_UDR = 8'h20;
    localparam logic [7:0] S_CIR = 8'h40;
    localparam logic [7:0] S_UIR = 8'h80;

    typedef logic [7:0] bq_t[$];

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_is_ir = 1'b0;
    logic [IR_W-1:0]  cmd_ir = '0;
    logic [DR_W-1:0]  cmd_data = '0;
    logic [LEN_W-1:0] cmd_len = '0;
    logic             cmd_ready;
    logic             rsp_valid;
    logic [DR_W-1:0]  rsp_data;
    logic [IR_W-1:0]  rsp_ir;
    logic [IR_W-1:0]  ir_out_drv = '0;
    logic             lb_reg = 1'b0;

    int checks = 0;
    int failures = 0;
    int rsp_cnt = 0;

    logic [7:0]      trace_q[$];
    logic            tdi_q[$];
    logic [IR_W-1:0] irin_q[$];

    always #5 clk = ~clk;

    vjtag_if #(.IR_W(IR_W)) vj ();

    assign vj.ir_out = ir_out_drv;
    assign vj.tdo    = lb_reg;

    vjtag_driver #(
        .IR_W      (IR_W),
        .DR_W      (DR_W),
        .TCK_DIV   (TCK_DIV),
        .PAUSE_TCKS(PAUSE_TCKS)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .cmd_valid_i(cmd_valid),
        .cmd_ready_o(cmd_ready),
        .cmd_is_ir_i(cmd_is_ir),
        .cmd_ir_i   (cmd_ir),
        .cmd_data_i (cmd_data),
        .cmd_len_i  (cmd_len),
        .rsp_valid_o(rsp_valid),
        .rsp_data_o (rsp_data),
        .rsp_ir_o   (rsp_ir),
        .vjtag      (vj)
    );

    wire [7:0] strobes = {vj.virtual_state_uir, vj.virtual_state_cir, vj.virtual_state_udr,
                          vj.virtual_state_e2dr, vj.virtual_state_pdr, vj.virtual_state_e1dr,
                          vj.virtual_state_sdr, vj.virtual_state_cdr};

    // Consumer side: everything is observed at tck rise.
    always @(posedge vj.tck) begin
        if (strobes != 8'h00) trace_q.push_back(strobes);
        if (vj.virtual_state_sdr) tdi_q.push_back(vj.tdi);
        if (vj.virtual_state_uir) irin_q.push_back(vj.ir_in);
        if (vj.virtual_state_cdr) lb_reg <= 1'b0;
        else if (vj.virtual_state_sdr) lb_reg <= vj.tdi;
    end

    always @(posedge clk) begin
        if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int eff_len(input int len);
        return (len > DR_W) ? DR_W : len;
    endfunction

    // Loopback slave: bit 0 sees the cleared register, bit k sees tdi bit k-1.
    function automatic logic [DR_W-1:0] exp_cap(input logic [DR_W-1:0] d, input int leff);
        logic [15:0] m;
        m = (16'd1 << leff) - 16'd1;
        return DR_W'((16'(d) << 1) & m);
    endfunction

    function automatic bq_t exp_trace(input logic is_ir, input int leff);
        bq_t q;
        if (is_ir) begin
            q.push_back(S_CIR);
            q.push_back(S_UIR);
        end else begin
            q.push_back(S_CDR);
            for (int k = 0; k < leff; k++) q.push_back(S_SDR);
            q.push_back(S_E1);
`ifdef VJTAG_DRV_PAUSE_EN
            for (int k = 0; k < PAUSE_TCKS; k++) q.push_back(S_PDR);
            q.push_back(S_E2);
`endif
            q.push_back(S_UDR);
        end
        return q;
    endfunction

    function automatic int scan_periods(input logic is_ir, input int leff);
        int p;
        if (is_ir) return 2;
        p = leff + 3;
`ifdef VJTAG_DRV_PAUSE_EN
        p = p + PAUSE_TCKS + 1;
`endif
        return p;
    endfunction

    task automatic compare_trace(input string tag, input int base, input bq_t exp_q);
        int got;
        got = trace_q.size() - base;
        check({tag, "_trace_len"}, got, exp_q.size());
        for (int k = 0; k < exp_q.size() && k < got; k++)
            check({tag, "_trace_state"}, trace_q[base + k], exp_q[k]);
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!cmd_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) check({tag, "_ready_timeout"}, 0, 1);
    endtask

    task automatic run_cmd(input string tag, input logic is_ir, input logic [IR_W-1:0] ir,
                           input logic [DR_W-1:0] data, input int len,
                           input logic [IR_W-1:0] irout_val);
        int tb, db, ib, rb, n, leff, per;
        logic ready_bad;
        bq_t exp_q;
        leff = is_ir ? 0 : eff_len(len);
        per  = scan_periods(is_ir, leff);
        ir_out_drv = irout_val;
        @(negedge clk);
        wait_ready(tag);
        tb = trace_q.size();
        db = tdi_q.size();
        ib = irin_q.size();
        rb = rsp_cnt;
        cmd_is_ir = is_ir;
        cmd_ir    = ir;
        cmd_data  = data;
        cmd_len   = LEN_W'(len);
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check({tag, "_ready_drop"}, cmd_ready, 0);
        n = 1;
        ready_bad = 1'b0;
        while (!rsp_valid && n < 400) begin
            @(negedge clk);
            n++;
            if (cmd_ready && !rsp_valid) ready_bad = 1'b1;
        end
        check({tag, "_rsp_seen"}, rsp_valid, 1);
        check({tag, "_ready_low_in_scan"}, ready_bad, 0);
        check({tag, "_ready_at_rsp"}, cmd_ready, 1);
        check({tag, "_latency_in_window"},
              (n >= per * TCK_CLKS + 1) && (n <= per * TCK_CLKS + TCK_CLKS), 1);
        if (is_ir) begin
            check({tag, "_rsp_ir"}, rsp_ir, irout_val);
            check({tag, "_ir_in_count"}, irin_q.size() - ib, 1);
            if (irin_q.size() > ib) check({tag, "_ir_in_at_uir"}, irin_q[ib], ir);
            check({tag, "_ir_in_hold"}, vj.ir_in, ir);
        end else begin
            check({tag, "_rsp_data"}, rsp_data, exp_cap(data, leff));
            check({tag, "_tdi_count"}, tdi_q.size() - db, leff);
            for (int k = 0; k < leff && db + k < tdi_q.size(); k++)
                check({tag, "_tdi_bit"}, tdi_q[db + k], data[k]);
        end
        exp_q = exp_trace(is_ir, leff);
        compare_trace(tag, tb, exp_q);
        @(negedge clk);
        check({tag, "_rsp_single_pulse"}, rsp_valid, 0);
        check({tag, "_rsp_count"}, rsp_cnt - rb, 1);
        $display("txn %s is_ir=%0d ir=%0h data=%0h len=%0d -> rsp_data=%0h rsp_ir=%0h lat=%0d",
                 tag, is_ir, ir, data, len, rsp_data, rsp_ir, n);
    endtask

    initial begin
        int n, rb, tb, db;
        logic ready_bad;
        logic [DR_W-1:0] d;
        bq_t exp_q;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", cmd_ready, 0);
        check("rst_tck", vj.tck, 0);
        check("rst_strobes", strobes, 0);
        check("rst_tdi", vj.tdi, 0);
        check("rst_ir_in", vj.ir_in, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_ir", rsp_ir, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", cmd_ready, 1);
        $display("txn reset release ready=%0d", cmd_ready);

        // Directed cases
        run_cmd("ir_101", 1'b1, 3'b101, 8'h00, 0, 3'b010);
        run_cmd("dr_a5", 1'b0, 3'b000, 8'hA5, 8, 3'b000);
        check("dr_a5_rsp_ir_held", rsp_ir, 3'b010);
        run_cmd("dr_len0", 1'b0, 3'b000, 8'hFF, 0, 3'b000);
        run_cmd("dr_len12", 1'b0, 3'b000, 8'h3C, 12, 3'b000);

        // Reset in the middle of SDR after three bits
        @(negedge clk);
        wait_ready("mid_rst");
        db = tdi_q.size();
        cmd_is_ir = 1'b0;
        cmd_data  = 8'hC3;
        cmd_len   = LEN_W'(8);
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (tdi_q.size() < db + 3 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("mid_rst_reached_sdr", tdi_q.size() >= db + 3, 1);
        rb = rsp_cnt;
        rst = 1'b1;
        #1;
        check("mid_rst_tck", vj.tck, 0);
        check("mid_rst_strobes", strobes, 0);
        check("mid_rst_ready", cmd_ready, 0);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_ready_after", cmd_ready, 1);
        repeat (3 * TCK_CLKS) @(negedge clk);
        check("mid_rst_no_rsp", rsp_cnt - rb, 0);
        $display("txn mid-scan reset ready=%0d rsp_pulses=%0d", cmd_ready, rsp_cnt - rb);
        run_cmd("after_rst", 1'b0, 3'b000, 8'h96, 5, 3'b000);

        // Back-to-back commands with cmd_valid held high
        @(negedge clk);
        wait_ready("b2b");
        rb = rsp_cnt;
        tb = trace_q.size();
        cmd_is_ir = 1'b0;
        cmd_data  = 8'h5B;
        cmd_len   = LEN_W'(6);
        cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("b2b_ready_drop", cmd_ready, 0);
            n = 1;
            ready_bad = 1'b0;
            while (!rsp_valid && n < 400) begin
                @(negedge clk);
                n++;
                if (cmd_ready && !rsp_valid) ready_bad = 1'b1;
            end
            check("b2b_rsp_seen", rsp_valid, 1);
            check("b2b_ready_low_in_scan", ready_bad, 0);
            check("b2b_rsp_data", rsp_data, exp_cap(8'h5B, 6));
            if (i == 2) cmd_valid = 1'b0;
            $display("txn b2b #%0d rsp_data=%0h lat=%0d", i, rsp_data, n);
        end
        repeat (4 * TCK_CLKS) @(negedge clk);
        check("b2b_rsp_count", rsp_cnt - rb, 3);
        exp_q = exp_trace(1'b0, 6);
        check("b2b_trace_len", trace_q.size() - tb, 3 * exp_q.size());

        // Randomized commands against the model
        for (int i = 0; i < 14; i++) begin
            logic            r_ir;
            logic [IR_W-1:0] r_irv, r_out;
            int              r_len;
            r_ir  = 1'($urandom_range(0, 1));
            r_irv = IR_W'($urandom);
            r_out = IR_W'($urandom);
            d     = DR_W'($urandom);
            r_len = $urandom_range(0, 12);
            run_cmd($sformatf("rnd%0d", i), r_ir, r_irv, d, r_len, r_out);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vjtag_driver.md
Name: vjtag_driver

Overview:
- Synthesizable driver for the virtual-JTAG bundle `vjtag_if`, acting as the host side (drives the `out` modport).
- Executes IR and DR scan commands taken from a valid/ready port on the system clock.
- Generates tck, the tap-state strobes, ir_in and serial tdi; samples tdo and returns the captured data.
- Used for cable-less self-test of vjtag user logic and as the simulation stimulus for it.

Parameters:
- IR_W, 3, width of ir_in/ir_out; must match the vjtag_if instance.
- DR_W, 32, maximum DR scan length in bits.
- TCK_DIV, 4, clk_i cycles per tck half-period; must be >= 1.
- PAUSE_TCKS, 2, tck periods spent in PDR (only with the optional feature); must be >= 1.

Ports:
- clk_i  input  1  system clock.
- rst_i  input  1  asynchronous, active-high reset.
- cmd_valid_i  input  1  command request.
- cmd_ready_o  output  1  high only in IDLE.
- cmd_is_ir_i  input  1  1 = IR scan, 0 = DR scan.
- cmd_ir_i  input  IR_W  value loaded to ir_in (IR scan).
- cmd_data_i  input  DR_W  tdi data, shifted LSB first (DR scan).
- cmd_len_i  input  $clog2(DR_W+1)  DR bit count.
- rsp_valid_o  output  1  one-clk pulse, command complete.
- rsp_data_o  output  DR_W  captured tdo bits, bit i = i-th shifted bit; upper bits 0.
- rsp_ir_o  output  IR_W  ir_out sampled at CIR.
- vjtag  vjtag_if.out  -  driven bundle.

Behaviour:
- Reset (async, rst_i=1): everything returns to its idle value.
  - FSM = IDLE; tck = 0; tdi = 0; ir_in = 0; all virtual_state_* = 0.
  - cmd_ready_o = 0 while rst_i is asserted, 1 after release.
  - rsp_valid_o = 0; rsp_data_o = 0; rsp_ir_o = 0.
- Reset mid-scan aborts the scan immediately; no rsp pulse is produced.
- tck generation:
  - Free-running; toggles every TCK_DIV clk_i cycles once out of reset.
  - "Fall" = clk where tck goes 1->0; "rise" = clk where tck goes 0->1.
- Timing of driven signals:
  - All strobes, tdi and ir_in change only at fall.
  - Each state holds for exactly one tck period, except SDR.
  - Consumers sample at rise.
- Handshake:
  - Command accepted when cmd_valid_i && cmd_ready_o; fields are registered and cmd_ready_o drops the next clk.
  - The first state strobe appears at the next fall.
- IR scan sequence: IDLE -> CIR -> UIR -> IDLE.
  - rsp_ir_o := ir_out sampled at the CIR rise.
  - ir_in := cmd_ir_i at the fall entering UIR; it holds that value until the next IR scan.
- DR scan sequence: IDLE -> CDR -> SDR x len -> E1DR -> UDR -> IDLE.
  - In SDR, tdi = bit k for the k-th period.
  - tdo is captured at each SDR rise into rsp_data_o bit k.
- cmd_len_i = 0: SDR is skipped (CDR -> E1DR -> UDR); rsp_data_o = 0.
- cmd_len_i > DR_W: clamped to DR_W.
- Strobes are one-hot; all are 0 in IDLE.
- rsp_valid_o pulses for one clk at the fall ending UIR/UDR.
  - The FSM re-enters IDLE on that same fall; cmd_ready_o = 1 on the same clk.
  - rsp_data_o / rsp_ir_o hold until the next completion.
- cmd_valid_i asserted during a scan is ignored; no queueing.
- Latency for a DR scan, from acceptance to rsp: (len+3) tck periods plus up to one tck period of alignment to the next fall.

Optional Feature:
- Macro: VJTAG_DRV_PAUSE_EN.
- Defined: the DR sequence becomes E1DR -> PDR x PAUSE_TCKS -> E2DR -> UDR.
  - virtual_state_pdr and virtual_state_e2dr are asserted accordingly.
  - For len = 0 the sequence becomes CDR -> E1DR -> PDR... as well.
- Undefined: E1DR -> UDR directly; pdr/e2dr are tied 0 and the PDR/E2DR states and their counter are not built.

Decomposition:
- Package `vjtag_drv_pkg` holds:
  - the state enum `vjtag_drv_state_t` (IDLE, CIR, UIR, CDR, SDR, E1DR, PDR, E2DR, UDR);
  - the width function for cmd_len.
- One sub-module, `vjtag_tck_gen`: divider producing tck plus the rise/fall single-clk pulses.
- FSM, shifter and response registers live in vjtag_driver.

Test Plan:
- TCK_DIV=2, IR_W=3: IR scan with cmd_ir_i=3'b101, slave drives ir_out=3'b010.
  - Required: cir for 1 tck, then uir for 1 tck with ir_in=3'b101.
  - Required: rsp_ir_o=3'b010, rsp_valid_o a single pulse.
- DR_W=8: DR scan of len 8, cmd_data_i=8'hA5, with a loopback slave (tdo = previous tdi).
  - Required: tdi sequence 1,0,1,0,0,1,0,1.
  - Required: sdr held 8 tck periods, rsp_data_o = 8'h4A given slave reset value 0.
- len=0, then len=12 with DR_W=8.
  - Required for len=0: no sdr, rsp_data_o=0.
  - Required for len=12: exactly 8 sdr periods.
- Assert rst_i mid-SDR (after 3 bits).
  - Required: all strobes and tck are 0 immediately; no rsp_valid_o.
  - Required: cmd_ready_o=1 after release, and the next command completes normally.
- cmd_valid_i held high continuously.
  - Required: back-to-back commands with cmd_ready_o low throughout each scan, and exactly one rsp pulse per command.
- With VJTAG_DRV_PAUSE_EN and PAUSE_TCKS=2.
  - Required: e1dr 1, pdr 2, e2dr 1, udr 1 tck periods, in that order.
